// File: rtl/redirect_ctrl_pkg.sv
// Shared defines for the front-end redirect path: BPU op codes, redirect FSM
// state encodings and the reset defaults used by redirect_ctrl.
package redirect_ctrl_pkg;

  // Branch-unit operation codes decoded by the IDU.
  typedef enum logic [3:0] {
    BPU_OP_NONE = 4'd0,
    BPU_OP_BEQ  = 4'd1,
    BPU_OP_BNE  = 4'd2,
    BPU_OP_BLT  = 4'd3,
    BPU_OP_BGE  = 4'd4,
    BPU_OP_BLTU = 4'd5,
    BPU_OP_BGEU = 4'd6,
    BPU_OP_JAL  = 4'd7,
    BPU_OP_JALR = 4'd8
  } bpu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_BUBBLE   = 2'd2
  } rd_state_e;

  localparam logic [31:0] RESET_PC_DEF      = 32'h8000_0000;
  localparam int unsigned BUBBLE_CYCLES_DEF = 2;

  function automatic logic is_aligned4(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/redirect_perf.sv
// Accepted-branch and taken-redirect performance counters for redirect_ctrl.
// Only present in builds with REDIRECT_PERF_EN defined.
`ifdef REDIRECT_PERF_EN
module redirect_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_accept_i,
  input  logic        taken_i,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] taken_cnt_o
);

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;

  // Next-count logic; both counters wrap naturally at 2^32.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (br_accept_i) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end else begin
      branch_cnt_d = branch_cnt_q;
    end
    if (taken_i) begin
      taken_cnt_d = taken_cnt_q + 32'd1;
    end else begin
      taken_cnt_d = taken_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q <= 32'd0;
      taken_cnt_q  <= 32'd0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign branch_cnt_o = branch_cnt_q;
  assign taken_cnt_o  = taken_cnt_q;

endmodule
`endif

// File: rtl/redirect_ctrl.sv
// Fetch redirect controller: turns resolved taken branches into an IFU redirect
// followed by a wrong-path squash window. Define REDIRECT_PERF_EN for counters.
module redirect_ctrl
  import redirect_ctrl_pkg::*;
#(
  parameter int unsigned BUBBLE_CYCLES = BUBBLE_CYCLES_DEF,
  parameter logic [31:0] RESET_PC      = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_valid_i,
  output logic        br_ready_o,
  input  logic        branch_en_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] dnpc_i,
  output logic        redirect_valid_o,
  input  logic        redirect_ready_i,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic        misalign_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] taken_cnt_o
);

  localparam logic [2:0] BUBBLE_LOAD = 3'(BUBBLE_CYCLES - 1);

  rd_state_e   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        misalign_q, misalign_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic        flush_q, flush_d;

  logic [31:0] seq_pc;
  logic        br_accept;
  logic        br_misalign;
  logic        br_redirect;

  // Ready is gated by rst so nothing is accepted while reset is held.
  assign seq_pc      = pc_i + 32'd4;
  assign br_ready_o  = (state_q == ST_IDLE) && !rst;
  assign br_accept   = br_valid_i && br_ready_o;
  assign br_misalign = br_accept && branch_en_i && !is_aligned4(dnpc_i);
  assign br_redirect = br_accept && branch_en_i && is_aligned4(dnpc_i) &&
                       (dnpc_i != seq_pc);

  // Next-state and registered-output logic of the redirect FSM.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    redirect_pc_d    = redirect_pc_q;
    misalign_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (br_redirect) begin
          state_d       = ST_REDIRECT;
          redirect_pc_d = dnpc_i;
        end else if (br_misalign) begin
          misalign_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready_i) begin
          state_d = ST_BUBBLE;
          cnt_d   = BUBBLE_LOAD;
        end else begin
          state_d = ST_REDIRECT;
        end
      end
      ST_BUBBLE: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
    redirect_valid_d = (state_d == ST_REDIRECT);
    flush_d          = (state_d != ST_IDLE);
  end

  // State and output registers; reset overrides any in-flight redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= 3'd0;
      redirect_pc_q    <= RESET_PC;
      misalign_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_pc_q    <= redirect_pc_d;
      misalign_q       <= misalign_d;
      redirect_valid_q <= redirect_valid_d;
      flush_q          <= flush_d;
    end
  end

  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign flush_o          = flush_q;
  assign misalign_o       = misalign_q;

`ifdef REDIRECT_PERF_EN
  redirect_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .br_accept_i  (br_accept),
    .taken_i      (br_redirect),
    .branch_cnt_o (branch_cnt_o),
    .taken_cnt_o  (taken_cnt_o)
  );
`else
  assign branch_cnt_o = 32'd0;
  assign taken_cnt_o  = 32'd0;
`endif

endmodule
